// File: rtl/param_dp_memory_pkg.sv
// Shared definitions for the parameterised dual-port memory.
//   - state_e : control FSM state (INIT clears the array, READY serves requests)
//   - RDW_OLD / RDW_NEW : read-during-write behaviour selectors
package param_dp_memory_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/param_dp_memory_init.sv
// Clear sequencer for param_dp_memory.
// After reset it walks every address once, requesting a zero write per cycle,
// then settles in READY for good (until the next reset).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear_en    : a zero write to clear_addr is requested this cycle
//   clear_addr  : address being cleared
//   init_busy   : clear sequence in progress (requests must be ignored)
//   dbg_state   : current FSM state (0 = INIT, 1 = READY)
module param_dp_memory_init
  import param_dp_memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clear_en,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  init_busy,
  output logic                  dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam state_e                RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : READY;

  state_e                r_state;
  state_e                w_next_state;
  logic [ADDR_WIDTH-1:0] r_clear_cnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RESET_STATE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: leave INIT on the edge that writes the last address
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT:    if (r_clear_cnt == LAST_ADDR) w_next_state = READY;
      READY:   w_next_state = READY;
      default: w_next_state = RESET_STATE;
    endcase
  end

  // Clear counter; it wraps back to 0 on the final clear, which is harmless
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_clear_cnt <= '0;
    else if (r_state == INIT) r_clear_cnt <= r_clear_cnt + ADDR_WIDTH'(1);
  end

  // Outputs
  always_comb begin
    clear_en   = (r_state == INIT);
    init_busy  = (r_state == INIT);
    clear_addr = r_clear_cnt;
    dbg_state  = r_state;
  end

endmodule

// File: rtl/param_dp_memory.sv
// Parameterised simple dual-port memory (one write port, one read port, one
// clock) with byte enables, 1- or 2-cycle registered reads, selectable
// read-during-write behaviour and an optional post-reset zero-fill.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   write_en/addr/data/be         : write request, applied on the same edge
//   read_en/read_addr             : read request
//   read_data, read_valid         : registered read word and its 1-cycle strobe
//   init_busy                     : zero-fill running; all requests are dropped
//   dbg_state                     : control FSM state (0 = INIT, 1 = READY)
// Handshake: there is no backpressure. A request is taken on any rising edge
// where its enable is high and init_busy is low; a read taken at edge N is
// presented with read_valid=1 for exactly one cycle, sampled at edge
// N+READ_LATENCY. read_data holds its value between valid strobes.
module param_dp_memory
  import param_dp_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_en,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_be,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    init_busy,
  output logic                    dbg_state
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("param_dp_memory: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH == 0) begin : g_bad_width
      $error("param_dp_memory: DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  logic                  w_clear_en;
  logic [ADDR_WIDTH-1:0] w_clear_addr;
  logic                  w_init_busy;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_rdw_hit;
  logic [DATA_WIDTH-1:0] w_mem_word;
  logic [DATA_WIDTH-1:0] w_merged_word;
  logic [DATA_WIDTH-1:0] w_read_word;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;

  param_dp_memory_init #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init (
    .clk        (clk),
    .rst        (rst),
    .clear_en   (w_clear_en),
    .clear_addr (w_clear_addr),
    .init_busy  (w_init_busy),
    .dbg_state  (dbg_state)
  );

  assign w_wr_fire = write_en & ~w_init_busy;
  assign w_rd_fire = read_en  & ~w_init_busy;

  // Storage array: no reset on purpose; only the clear sequence zeroes it.
  // clear_en and user writes are mutually exclusive because writes are
  // gated by init_busy.
  always_ff @(posedge clk) begin
    if (w_clear_en) begin
      r_mem[w_clear_addr] <= '0;
    end else if (w_wr_fire) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (write_be[k]) r_mem[write_addr][8*k +: 8] <= write_data[8*k +: 8];
      end
    end
  end

  // Word the read port would see if the pending write had already landed
  always_comb begin
    w_mem_word    = r_mem[read_addr];
    w_merged_word = w_mem_word;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (write_be[k]) w_merged_word[8*k +: 8] = write_data[8*k +: 8];
    end
  end

  // Bypass only when a write really happens to the same address this edge;
  // in old-data mode the array read already returns the pre-write word.
  assign w_rdw_hit   = (RDW_MODE == RDW_NEW) && w_wr_fire && (write_addr == read_addr);
  assign w_read_word = w_rdw_hit ? w_merged_word : w_mem_word;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_s1_valid;
      logic [DATA_WIDTH-1:0] r_s1_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1_valid   <= 1'b0;
          r_s1_data    <= '0;
          r_read_valid <= 1'b0;
          r_read_data  <= '0;
        end else begin
          r_s1_valid   <= w_rd_fire;
          if (w_rd_fire)  r_s1_data   <= w_read_word;
          r_read_valid <= r_s1_valid;
          if (r_s1_valid) r_read_data <= r_s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_read_valid <= 1'b0;
          r_read_data  <= '0;
        end else begin
          r_read_valid <= w_rd_fire;
          if (w_rd_fire) r_read_data <= w_read_word;
        end
      end
    end
  endgenerate

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign init_busy  = w_init_busy;

endmodule
